mux_8_1_scan_ctrl: RTL and testbench
====================================

Name: mux_8_1_scan_ctrl

Overview:
Channel scanner that sits around the 8:1 structural mux. It drives the mux selects S2/S1/S0 through the enabled channels in ascending order and samples the mux output Z after a settle time. It packs the sampled bits into an 8-bit word and hands that word downstream over a VALID/READY handshake. It turns eight single-bit lines into one parallel word per scan request.

Parameters:
SETTLE_CYCLES, 2, clock cycles each select value is held before Z is sampled; legal range 1..15.

Ports:
CLK  input  1  system clock; all state updates on rising edge
RST  input  1  synchronous, active-high reset
START  input  1  scan request; sampled only in IDLE
MASK  input  8  channel enable; bit i enables channel i (A=0 … H=7); captured on accepted START
Z  input  1  output of the 8:1 mux
S2  output  1  mux select bit 2 (MSB)
S1  output  1  mux select bit 1
S0  output  1  mux select bit 0 (LSB)
BUSY  output  1  high while a scan is in progress
DATA  output  8  scan result; bit i = sampled Z for channel i, 0 for masked channels
VALID  output  1  DATA valid; held until accepted
READY  input  1  downstream accepts DATA when VALID&&READY

Behaviour:
- Reset (RST=1 at an edge): state=IDLE, {S2,S1,S0}=3'b000, BUSY=0, VALID=0, DATA=8'h00, settle counter=0, captured mask=0.
- RST has priority over all inputs. A reset mid-scan aborts the scan with no VALID.
- States: IDLE, SETTLE, DONE.
- IDLE:
  - START=1 at edge e0 → capture MASK.
  - If MASK≠0: select = lowest enabled channel index, BUSY=1, counter=1, clear internal result, go to SETTLE.
  - If MASK=0: DATA=8'h00, VALID=1, BUSY stays 0, go to DONE.
- SETTLE:
  - Select is held stable while counter < SETTLE_CYCLES; counter increments each cycle.
  - At the edge where counter==SETTLE_CYCLES, Z is written to result bit[select].
  - If a higher enabled channel exists: select moves to the next higher enabled index, counter=1.
  - Otherwise: DATA = result including the bit just sampled, VALID=1, BUSY=0, go to DONE.
  - START is ignored during SETTLE.
- DONE:
  - VALID and DATA are held stable until READY=1.
  - On VALID&&READY: VALID=0 next cycle, go to IDLE.
  - START is ignored in DONE, including when START and READY are both high in the same cycle. START must be high again in IDLE to be accepted.
- Selects hold their last value in IDLE and DONE. They change only on channel advance or reset.
- Latency, with N = number of set bits in the captured mask:
  - VALID rises N·SETTLE_CYCLES edges after e0.
  - With MASK=0, VALID rises 1 edge after e0.
- Masked channels are never selected. A channel is skipped in zero cycles; no dead cycles between channels.
- MASK changes after capture have no effect on the scan in progress.
- Z is assumed stable after SETTLE_CYCLES−1 full cycles of stable select. There is no internal synchroniser.

Optional Feature:
Macro SCAN_CONTINUOUS_EN.
- Defined: on the VALID&&READY edge in DONE, MASK is recaptured and a new scan starts immediately, as if START were accepted at that edge (MASK=0 re-enters DONE with DATA=0 one edge later). The block leaves the continuous loop only via RST. START is still required for the first scan after reset.
- Not defined: behaviour exactly as above; each scan needs its own START.

Test Plan:
- Reset: assert RST 3 cycles with START=1 → S2..S0=000, BUSY=0, VALID=0, DATA=00; no scan starts.
- Full scan: SETTLE_CYCLES=2, MASK=FF, A..H=1,0,1,1,0,0,1,0, START pulse at e0 → selects step 0..7, each held 2 cycles; VALID at e0+16; DATA=8'h4D; BUSY high from e0 until VALID.
- Sparse mask: MASK=8'h82, B=1, H=1, others 1 → only selects 001 then 111 appear; VALID at e0+4; DATA=8'h82.
- Zero mask: MASK=00, START → VALID at e0+1, DATA=00, BUSY never high, selects unchanged.
- Backpressure: hold READY=0 for 10 cycles after VALID; toggle Z and pulse START → VALID/DATA stable, no new scan; READY=1 with START=1 the same cycle → VALID drops, state returns to IDLE, no scan until a later START.
- Mid-scan reset: RST at e0+5 of the full scan → all outputs return to reset values next edge; no VALID; a subsequent START performs a clean full scan. With SCAN_CONTINUOUS_EN defined: after the first READY handshake, a second scan starts without START and VALID reappears 16 edges later.

Source files
------------

// File: rtl/mux_8_1_scan_ctrl.sv
// mux_8_1_scan_ctrl: steps the 8:1 mux selects through the enabled channels
// in ascending order, samples Z after a settle time, and hands the packed
// 8-bit result downstream over a VALID/READY handshake.
// Optional build macro: SCAN_CONTINUOUS_EN (restart a scan on every accepted
// result instead of waiting for a fresh START).
module mux_8_1_scan_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START,
   input  logic [7:0] MASK,
   input  logic       Z,
   output logic       S2,
   output logic       S1,
   output logic       S0,
   output logic       BUSY,
   output logic [7:0] DATA,
   output logic       VALID,
   input  logic       READY
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned CH_W  = 3;
   localparam int unsigned DW    = 8;
   localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SETTLE_CYCLES);

   typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

   state_t            state_q, state_d;
   logic [CH_W-1:0]   sel_q, sel_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DW-1:0]     mask_q, mask_d;
   logic [DW-1:0]     res_q, res_d;
   logic [DW-1:0]     data_q, data_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;

   logic [DW-1:0]     above;
   logic [DW-1:0]     res_smp;
   logic              launch;

   // Index of the lowest set bit (0 when none is set).
   function automatic logic [CH_W-1:0] lowest_ch(input logic [DW-1:0] v);
      lowest_ch = '0;
      for (int i = DW - 1; i >= 0; i--) begin
         if (v[i]) lowest_ch = CH_W'(i);
      end
   endfunction

   // State and datapath registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         sel_q   <= '0;
         cnt_q   <= '0;
         mask_q  <= '0;
         res_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         mask_q  <= mask_d;
         res_q   <= res_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state logic: settle/sample/advance sequencing and handshake.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      mask_d  = mask_q;
      res_d   = res_q;
      data_d  = data_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      launch  = 1'b0;

      // Enabled channels strictly above the current select.
      above   = mask_q & (8'hFF << ({1'b0, sel_q} + 4'd1));
      res_smp = res_q;
      res_smp[sel_q] = Z;

      case (state_q)
         IDLE: begin
            launch = START;
         end
         SETTLE: begin
            if (cnt_q < SETTLE_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end else if (above != '0) begin
               sel_d = lowest_ch(above);
               cnt_d = CNT_W'(1);
               res_d = res_smp;
            end else begin
               res_d   = res_smp;
               data_d  = res_smp;
               valid_d = 1'b1;
               busy_d  = 1'b0;
               state_d = DONE;
            end
         end
         DONE: begin
            // An empty mask enters DONE with VALID low; raise it one edge later.
            if (!valid_q) begin
               valid_d = 1'b1;
            end else if (READY) begin
               valid_d = 1'b0;
               state_d = IDLE;
`ifdef SCAN_CONTINUOUS_EN
               launch  = 1'b1;
`else
               launch  = 1'b0;
`endif
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Accepted scan request: capture the mask and pick the first channel.
      if (launch) begin
         mask_d = MASK;
         res_d  = '0;
         if (MASK != '0) begin
            sel_d   = lowest_ch(MASK);
            cnt_d   = CNT_W'(1);
            busy_d  = 1'b1;
            state_d = SETTLE;
         end else begin
            data_d  = '0;
            state_d = DONE;
         end
      end
   end

   assign {S2, S1, S0} = sel_q;
   assign BUSY  = busy_q;
   assign DATA  = data_q;
   assign VALID = valid_q;

endmodule

// File: tb/tb_mux_8_1_scan_ctrl.sv
// Directed bench for mux_8_1_scan_ctrl with a behavioural 8:1 mux on Z.
module tb_mux_8_1_scan_ctrl;

   localparam int unsigned SC = 2;

   logic       CLK = 1'b0;
   logic       RST, START, Z, READY;
   logic [7:0] MASK;
   logic       S2, S1, S0, BUSY, VALID;
   logic [7:0] DATA;
   logic [7:0] chan;

   int n_vec = 0;
   int n_err = 0;

   mux_8_1_scan_ctrl #(.SETTLE_CYCLES(SC)) dut (
      .CLK(CLK), .RST(RST), .START(START), .MASK(MASK), .Z(Z),
      .S2(S2), .S1(S1), .S0(S0), .BUSY(BUSY), .DATA(DATA),
      .VALID(VALID), .READY(READY)
   );

   always #5 CLK = ~CLK;

   // Behavioural 8:1 mux: bit i of chan is channel i.
   assign Z = chan[{S2, S1, S0}];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   // Channel index of the n-th enabled bit of m, counting from bit 0.
   function automatic logic [2:0] nth_set(input logic [7:0] m, input int n);
      int k;
      k = 0;
      nth_set = '0;
      for (int i = 0; i < 8; i++) begin
         if (m[i]) begin
            if (k == n) nth_set = 3'(i);
            k++;
         end
      end
   endfunction

   task automatic run_scan(input string tag, input logic [7:0] m, input logic [7:0] exp_data);
      int n;
      logic [2:0] prev;
      n = $countones(m);
      prev = {S2, S1, S0};
      MASK = m;
      START = 1'b1;
      tick;
      START = 1'b0;
      if (n == 0) begin
         check({tag, ":bv_e0"}, {BUSY, VALID}, 2'b00);
         tick;
         check({tag, ":sel_hold"}, {S2, S1, S0}, prev);
      end else begin
         for (int c = 0; c < n * SC; c++) begin
            check({tag, ":sel"}, {S2, S1, S0}, nth_set(m, c / SC));
            check({tag, ":bv"}, {BUSY, VALID}, 2'b10);
            tick;
         end
      end
      check({tag, ":bv_end"}, {BUSY, VALID}, 2'b01);
      check({tag, ":data"}, DATA, exp_data);
   endtask

   task automatic release_data(input string tag);
      READY = 1'b1;
      tick;
      READY = 1'b0;
      check({tag, ":valid_drop"}, VALID, 1'b0);
`ifdef SCAN_CONTINUOUS_EN
      RST = 1'b1;
      tick;
      RST = 1'b0;
`endif
   endtask

   initial begin
      logic seen_valid;
      int   lat;

      RST = 1'b1; START = 1'b1; MASK = 8'hFF; READY = 1'b0;
      chan = 8'h4D;
      repeat (3) tick;
      check("rst_sel", {S2, S1, S0}, 3'b000);
      check("rst_bv", {BUSY, VALID}, 2'b00);
      check("rst_data", DATA, 8'h00);
      RST = 1'b0; START = 1'b0;
      tick; tick;
      check("rst_noscan", {BUSY, VALID}, 2'b00);

      // Channels A..H = 1,0,1,1,0,0,1,0
      run_scan("full", 8'hFF, 8'h4D);
      release_data("full");

      chan = 8'hFF;
      run_scan("sparse", 8'h82, 8'h82);
      release_data("sparse");

      run_scan("zero", 8'h00, 8'h00);
      release_data("zero");

      // Backpressure: result held while READY is low, START ignored.
      chan = 8'h4D;
      run_scan("bp_scan", 8'hFF, 8'h4D);
      for (int i = 0; i < 10; i++) begin
         chan = ~chan;
         START = i[0];
         tick;
         check("bp_hold", {BUSY, VALID, DATA}, {2'b01, 8'h4D});
      end
      chan = 8'h4D;
      START = 1'b1; READY = 1'b1;
      tick;
      START = 1'b0; READY = 1'b0;
      check("bp_valid_drop", VALID, 1'b0);
`ifdef SCAN_CONTINUOUS_EN
      check("bp_restart", BUSY, 1'b1);
      RST = 1'b1; tick; RST = 1'b0;
`else
      check("bp_idle", BUSY, 1'b0);
      seen_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick;
         seen_valid = seen_valid | BUSY | VALID;
      end
      check("bp_noscan", seen_valid, 1'b0);
`endif

      // Mid-scan reset at e0+5.
      MASK = 8'hFF; START = 1'b1;
      tick;
      START = 1'b0;
      repeat (4) tick;
      RST = 1'b1;
      tick;
      RST = 1'b0;
      check("mrst_sel", {S2, S1, S0}, 3'b000);
      check("mrst_bv", {BUSY, VALID}, 2'b00);
      check("mrst_data", DATA, 8'h00);
      seen_valid = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick;
         seen_valid = seen_valid | VALID;
      end
      check("mrst_novalid", seen_valid, 1'b0);
      run_scan("after_rst", 8'hFF, 8'h4D);
      release_data("after_rst");

`ifdef SCAN_CONTINUOUS_EN
      // Continuous: handshake edge restarts the scan without START.
      run_scan("cont1", 8'hFF, 8'h4D);
      READY = 1'b1;
      tick;
      READY = 1'b0;
      check("cont_restart", {BUSY, VALID}, 2'b10);
      lat = 0;
      while (!VALID && lat < 100) begin
         tick;
         lat++;
      end
      check("cont_latency", lat, 16);
      check("cont_data", DATA, 8'h4D);
      RST = 1'b1; tick; RST = 1'b0;
`else
      lat = 0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
